// File: rtl/apb_mem_slave_wait_if.sv
// APB bus bundle between the master/bench and the apb_mem_slave_wait peripheral.
interface apb_mem_slave_wait_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_W-1:0]     PADDR;
    logic [DATA_W-1:0]     PWDATA;
    logic [DATA_W/8-1:0]   PSTRB;
    logic                  PREADY;
    logic [DATA_W-1:0]     PRDATA;
    logic                  PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        input  PREADY, PRDATA, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        output PREADY, PRDATA, PSLVERR
    );
endinterface

// File: rtl/apb_mem_slave_wait.sv
// APB4 word-addressed memory slave with byte strobes, programmable wait
// states and PSLVERR on out-of-range or misaligned accesses.
// The setup phase is sampled on the clock edge that closes it, so the
// transfer is latched there and PREADY (fully registered) can already be
// high in the first access cycle when WAIT_STATES is 0.
module apb_mem_slave_wait #(
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 0
) (
    input  logic                PCLK,
    input  logic                PRESET,
    apb_mem_slave_wait_if.slave bus
);
    localparam int NB    = DATA_W / 8;
    localparam int LSB   = $clog2(NB);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t              state;
    logic [3:0]          cnt;
    logic                pready;
    logic [DATA_W-1:0]   prdata;
    logic                pslverr;

    // Transfer captured at the end of the setup phase
    logic [IDX_W-1:0]    idx_p0;
    logic                wr_p0;
    logic [DATA_W-1:0]   wdata_p0;
    logic [NB-1:0]       strb_p0;
    logic                err_p0;

    logic [DATA_W-1:0]   mem [DEPTH];

    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [NB-1:0]     strb
    );
        logic [DATA_W-1:0] res;
        res = old_word;
        for (int i = 0; i < NB; i++) begin
            if (strb[i]) res[8*i +: 8] = new_word[8*i +: 8];
        end
        return res;
    endfunction

    logic                setup_seen;
    logic [ADDR_W-1:0]   word_addr;
    logic                new_err;
    logic [IDX_W-1:0]    new_idx;
    logic                start;
    logic                commit;
    logic [DATA_W-1:0]   merged;
    logic [DATA_W-1:0]   read_now;

    assign setup_seen = bus.PSEL && !bus.PENABLE;
    assign word_addr  = bus.PADDR >> LSB;
    assign new_err    = ((bus.PADDR & ADDR_W'(NB - 1)) != '0) ||
                        (64'(word_addr) >= 64'(DEPTH));
    assign new_idx    = word_addr[IDX_W-1:0];
    assign start      = setup_seen && ((state == IDLE) || (state == ACCESS && pready));
    assign commit     = (state == ACCESS) && pready && bus.PSEL && wr_p0 && !err_p0;
    assign merged     = merge_bytes(mem[idx_p0], wdata_p0, strb_p0);
    // A back-to-back read of the word being committed sees the new data
    assign read_now   = (commit && (new_idx == idx_p0)) ? merged : mem[new_idx];

    assign bus.PREADY  = pready;
    assign bus.PRDATA  = prdata;
    assign bus.PSLVERR = pslverr;

    // Transfer FSM, wait counter, registered response and memory update
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state    <= IDLE;
            cnt      <= '0;
            pready   <= 1'b0;
            prdata   <= '0;
            pslverr  <= 1'b0;
            idx_p0   <= '0;
            wr_p0    <= 1'b0;
            wdata_p0 <= '0;
            strb_p0  <= '0;
            err_p0   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            pready  <= 1'b0;
            prdata  <= '0;
            pslverr <= 1'b0;
            if (commit) mem[idx_p0] <= merged;
            if (start) begin
                state    <= ACCESS;
                cnt      <= 4'(WAIT_STATES);
                idx_p0   <= new_idx;
                wr_p0    <= bus.PWRITE;
                wdata_p0 <= bus.PWDATA;
                strb_p0  <= bus.PSTRB;
                err_p0   <= new_err;
                if (WAIT_STATES == 0) begin
                    pready  <= 1'b1;
                    pslverr <= new_err;
                    prdata  <= (!bus.PWRITE && !new_err) ? read_now : '0;
                end
            end else if (state == ACCESS) begin
                if (pready || !bus.PSEL) begin
                    // Completed transfer, or master aborted by dropping PSEL
                    state <= IDLE;
                end else begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        pready  <= 1'b1;
                        pslverr <= err_p0;
                        prdata  <= (!wr_p0 && !err_p0) ? mem[idx_p0] : '0;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_apb_mem_slave_wait.sv
// Bench for apb_mem_slave_wait: two instances (0 and 2 wait states) share one
// APB master; PSEL is routed to the selected instance only. A per-instance
// array memory model predicts read data, errors and wait counts.
`timescale 1ns/1ps
module tb_apb_mem_slave_wait;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        psel, penable, pwrite;
    logic [11:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    int          sel;

    apb_mem_slave_wait_if #(.ADDR_W(12), .DATA_W(32)) if0 ();
    apb_mem_slave_wait_if #(.ADDR_W(12), .DATA_W(32)) if2 ();

    assign if0.PSEL = psel && (sel == 0);
    assign if2.PSEL = psel && (sel == 1);
    assign if0.PENABLE = penable;  assign if2.PENABLE = penable;
    assign if0.PWRITE  = pwrite;   assign if2.PWRITE  = pwrite;
    assign if0.PADDR   = paddr;    assign if2.PADDR   = paddr;
    assign if0.PWDATA  = pwdata;   assign if2.PWDATA  = pwdata;
    assign if0.PSTRB   = pstrb;    assign if2.PSTRB   = pstrb;

    apb_mem_slave_wait #(.ADDR_W(12), .DATA_W(32), .DEPTH(64), .WAIT_STATES(0)) dut0 (
        .PCLK(clk), .PRESET(rst), .bus(if0.slave));
    apb_mem_slave_wait #(.ADDR_W(12), .DATA_W(32), .DEPTH(64), .WAIT_STATES(2)) dut2 (
        .PCLK(clk), .PRESET(rst), .bus(if2.slave));

    int          vec = 0;
    int          miscompares = 0;
    logic [31:0] ref_mem [2][64];
    int          exp_waits [2] = '{0, 2};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic cur_ready();
        return (sel == 0) ? if0.PREADY : if2.PREADY;
    endfunction
    function automatic logic [31:0] cur_rdata();
        return (sel == 0) ? if0.PRDATA : if2.PRDATA;
    endfunction
    function automatic logic cur_err();
        return (sel == 0) ? if0.PSLVERR : if2.PSLVERR;
    endfunction

    task automatic clear_model();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 64; i++) ref_mem[d][i] = '0;
    endtask

    task automatic xfer(input int d, input bit wr, input logic [11:0] a,
                        input logic [31:0] wd, input logic [3:0] st,
                        input bit b2b, input string tag);
        int          waits;
        int          idx;
        bit          err;
        logic [31:0] exp_rd;
        idx = int'(a) / 4;
        err = (a[1:0] != 2'b00) || (idx >= 64);
        exp_rd = '0;
        if (!wr && !err) exp_rd = ref_mem[d][idx];
        @(negedge clk);
        sel = d; psel = 1'b1; penable = 1'b0;
        pwrite = wr; paddr = a; pwdata = wd; pstrb = st;
        @(negedge clk);
        penable = 1'b1;
        waits = 0;
        while (!cur_ready() && waits < 40) begin
            chk({tag, "_wait_rdata"}, cur_rdata(), 0);
            chk({tag, "_wait_slverr"}, cur_err(), 0);
            waits++;
            @(negedge clk);
        end
        chk({tag, "_ready"}, cur_ready(), 1);
        chk({tag, "_waits"}, waits, exp_waits[d]);
        chk({tag, "_slverr"}, cur_err(), err);
        if (!wr) chk({tag, "_rdata"}, cur_rdata(), exp_rd);
        if (wr && !err)
            for (int i = 0; i < 4; i++)
                if (st[i]) ref_mem[d][idx][8*i +: 8] = wd[8*i +: 8];
        if (!b2b) begin
            @(negedge clk);
            psel = 1'b0; penable = 1'b0;
            chk({tag, "_ready_low_after"}, cur_ready(), 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] ra;
        rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0; sel = 0;
        clear_model();
        repeat (2) @(negedge clk);
        chk("rst_ready0", if0.PREADY, 0);
        chk("rst_rdata0", if0.PRDATA, 0);
        chk("rst_slverr0", if0.PSLVERR, 0);
        chk("rst_ready2", if2.PREADY, 0);
        chk("rst_rdata2", if2.PRDATA, 0);
        chk("rst_slverr2", if2.PSLVERR, 0);
        rst = 1'b0;

        // Basic write/read, zero wait states
        xfer(0, 1, 12'h010, 32'h0000007B, 4'hF, 0, "w0_010");
        xfer(0, 0, 12'h010, 32'h0, 4'h0, 0, "r0_010");
        chk("r0_010_const", if0.PRDATA, 0);
        // Two wait states
        xfer(1, 1, 12'h010, 32'h0000007B, 4'hF, 0, "w2_010");
        xfer(1, 0, 12'h010, 32'h0, 4'h0, 0, "r2_010");
        // Byte strobes
        xfer(0, 1, 12'h020, 32'hAABBCCDD, 4'hF, 0, "w0_020a");
        xfer(0, 1, 12'h020, 32'h11223344, 4'h5, 0, "w0_020b");
        xfer(0, 0, 12'h020, 32'h0, 4'h0, 0, "r0_020");
        chk("strobe_model", ref_mem[0][8], 32'hAA22CC44);
        // Error responses: out of range (aliases index 61), misaligned
        xfer(0, 1, 12'd500, 32'd123, 4'hF, 0, "w0_oor");
        xfer(0, 0, 12'h0F4, 32'h0, 4'h0, 0, "r0_alias");
        xfer(0, 0, 12'h013, 32'h0, 4'h0, 0, "r0_misal");
        xfer(0, 1, 12'h011, 32'hFFFFFFFF, 4'hF, 0, "w0_misal");
        xfer(0, 0, 12'h010, 32'h0, 4'h0, 0, "r0_010_keep");
        xfer(1, 0, 12'd500, 32'h0, 4'h0, 0, "r2_oor");
        // Back-to-back transfers
        xfer(0, 1, 12'h040, 32'hCAFEF00D, 4'hF, 1, "b2b_w0");
        xfer(0, 0, 12'h040, 32'h0, 4'h0, 1, "b2b_r0");
        xfer(0, 0, 12'h010, 32'h0, 4'h0, 0, "b2b_r0b");
        xfer(1, 1, 12'h044, 32'h0BADBEEF, 4'hF, 1, "b2b_w2");
        xfer(1, 0, 12'h044, 32'h0, 4'h0, 0, "b2b_r2");

        // Protocol abort: PSEL dropped during a wait cycle leaves memory alone
        xfer(1, 1, 12'h050, 32'h5555AAAA, 4'hF, 0, "w2_050");
        @(negedge clk);
        sel = 1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 12'h050; pwdata = 32'h12345678; pstrb = 4'hF;
        @(negedge clk);
        penable = 1'b1;
        chk("abort_wait_ready", cur_ready(), 0);
        @(negedge clk);
        psel = 1'b0; penable = 1'b0;
        xfer(1, 0, 12'h050, 32'h0, 4'h0, 0, "r2_050_abort");

        // Randomised traffic
        for (int n = 0; n < 40; n++) begin
            ra = 12'($urandom_range(0, 300));
            if ($urandom_range(0, 3) != 0) ra[1:0] = 2'b00;
            xfer(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra,
                 $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), "rnd");
        end
        @(negedge clk);
        psel = 1'b0; penable = 1'b0;

        // Reset during a wait cycle of a write to 0x030
        @(negedge clk);
        sel = 1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 12'h030; pwdata = 32'h87654321; pstrb = 4'hF;
        @(negedge clk);
        penable = 1'b1;
        chk("mid_wait_ready", cur_ready(), 0);
        rst = 1'b1; psel = 1'b0; penable = 1'b0;
        #1;
        chk("mid_rst_ready", cur_ready(), 0);
        chk("mid_rst_rdata", cur_rdata(), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_model();
        xfer(1, 0, 12'h030, 32'h0, 4'h0, 0, "r2_030_after_rst");
        xfer(1, 0, 12'h010, 32'h0, 4'h0, 0, "r2_010_after_rst");

        // Reset while PREADY is high: PREADY must fall without a clock edge
        xfer(0, 1, 12'h030, 32'h01020304, 4'hF, 0, "w0_030");
        @(negedge clk);
        sel = 0; psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 12'h030; pwdata = 32'hFFFF0000; pstrb = 4'hF;
        @(negedge clk);
        penable = 1'b1;
        chk("ready_before_rst", cur_ready(), 1);
        rst = 1'b1;
        #1;
        chk("ready_drop_on_rst", cur_ready(), 0);
        chk("slverr_drop_on_rst", cur_err(), 0);
        psel = 1'b0; penable = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_model();
        xfer(0, 0, 12'h030, 32'h0, 4'h0, 0, "r0_030_after_rst");
        chk("r0_030_zero", if0.PRDATA, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miscompares);
        $finish;
    end
endmodule
